// File: rtl/up_down_pkg.sv
// Shared elevator types: floor count, destination-mask width and the
// per-floor flag vector used by the direction classifier.
package up_down_pkg;
  localparam int NUM_FLOORS = 7;
  localparam int MASK_W     = 6;
  localparam int CNT_W      = 3;  // per-floor count, 0..6
  localparam int TOT_W      = 5;  // all-floor total, 0..21

  typedef logic [MASK_W-1:0]     floor_mask_t;
  typedef logic [NUM_FLOORS-1:0] floor_vec_t;
  typedef logic [CNT_W-1:0]      floor_cnt_t;
  typedef logic [TOT_W-1:0]      total_t;

  function automatic floor_cnt_t popcnt(input floor_mask_t m);
    floor_cnt_t c;
    c = '0;
    for (int k = 0; k < MASK_W; k++) c = c + floor_cnt_t'(m[k]);
    return c;
  endfunction
endpackage

// File: rtl/up_down_if.sv
// Hall-request bundle: seven destination masks in, per-floor direction flags
// and request totals out.
interface up_down_if;
  import up_down_pkg::*;
  floor_mask_t passenger_1, passenger_2, passenger_3, passenger_4,
               passenger_5, passenger_6, passenger_7;
  floor_vec_t  up_passenger, down_passenger;
  total_t      up_total, down_total;

  modport master (
    output passenger_1, passenger_2, passenger_3, passenger_4,
           passenger_5, passenger_6, passenger_7,
    input  up_passenger, down_passenger, up_total, down_total
  );
  modport slave (
    input  passenger_1, passenger_2, passenger_3, passenger_4,
           passenger_5, passenger_6, passenger_7,
    output up_passenger, down_passenger, up_total, down_total
  );
endinterface

// File: rtl/up_down_floor_dir_split.sv
// Splits one floor's destination mask into its up/down halves; the floor
// itself is skipped, so bits below FLOOR-1 point to lower floors.
module floor_dir_split
  import up_down_pkg::*;
#(
  parameter int FLOOR = 1
) (
  input  floor_mask_t mask_i,
  output logic        up_any_o,
  output logic        down_any_o,
  output floor_cnt_t  up_cnt_o,
  output floor_cnt_t  down_cnt_o
);
  localparam floor_mask_t DN_SEL = floor_mask_t'((7'd1 << (FLOOR - 1)) - 7'd1);

  floor_mask_t up_m, dn_m;

  assign dn_m       = mask_i & DN_SEL;
  assign up_m       = mask_i & ~DN_SEL;
  assign up_any_o   = |up_m;
  assign down_any_o = |dn_m;
  assign up_cnt_o   = popcnt(up_m);
  assign down_cnt_o = popcnt(dn_m);
endmodule

// File: rtl/up_down.sv
// Per-floor up/down request flags and totals, registered with one cycle of
// latency; reset clears all outputs asynchronously.
module up_down
  import up_down_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  up_down_if.slave   bus
);
  floor_mask_t mask [NUM_FLOORS];
  floor_cnt_t  up_cnt [NUM_FLOORS];
  floor_cnt_t  dn_cnt [NUM_FLOORS];
  floor_vec_t  up_d, dn_d, up_q, dn_q;
  total_t      ut_d, dt_d, ut_q, dt_q;

  assign mask[0] = bus.passenger_1;
  assign mask[1] = bus.passenger_2;
  assign mask[2] = bus.passenger_3;
  assign mask[3] = bus.passenger_4;
  assign mask[4] = bus.passenger_5;
  assign mask[5] = bus.passenger_6;
  assign mask[6] = bus.passenger_7;

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_floor
    floor_dir_split #(.FLOOR(f + 1)) u_split (
      .mask_i     (mask[f]),
      .up_any_o   (up_d[f]),
      .down_any_o (dn_d[f]),
      .up_cnt_o   (up_cnt[f]),
      .down_cnt_o (dn_cnt[f])
    );
  end

  always_comb begin
    ut_d = '0;
    dt_d = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      ut_d = ut_d + total_t'(up_cnt[f]);
      dt_d = dt_d + total_t'(dn_cnt[f]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q <= '0;
      dn_q <= '0;
      ut_q <= '0;
      dt_q <= '0;
    end else begin
      up_q <= up_d;
      dn_q <= dn_d;
      ut_q <= ut_d;
      dt_q <= dt_d;
    end
  end

  assign bus.up_passenger   = up_q;
  assign bus.down_passenger = dn_q;
  assign bus.up_total       = ut_q;
  assign bus.down_total     = dt_q;
endmodule

// File: tb/tb_up_down.sv
// Directed vector table for the up/down request classifier plus reset and
// latency sequences.
module tb_up_down;
  import up_down_pkg::*;

  typedef logic [6:0][5:0] masks_t;  // [0] = floor 1
  typedef struct {
    string      name;
    masks_t     m;
    floor_vec_t up;
    floor_vec_t dn;
    total_t     ut;
    total_t     dt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t vecs [8];

  up_down_if bus ();
  up_down dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic masks_t mk(input logic [5:0] p1, p2, p3, p4, p5, p6, p7);
    masks_t r;
    r[0] = p1; r[1] = p2; r[2] = p3; r[3] = p4;
    r[4] = p5; r[5] = p6; r[6] = p7;
    return r;
  endfunction

  task automatic drive(input masks_t m);
    bus.passenger_1 = m[0]; bus.passenger_2 = m[1]; bus.passenger_3 = m[2];
    bus.passenger_4 = m[3]; bus.passenger_5 = m[4]; bus.passenger_6 = m[5];
    bus.passenger_7 = m[6];
  endtask

  task automatic check(input string name, input floor_vec_t up, dn,
                       input total_t ut, dt);
    total += 4;
    if (bus.up_passenger !== up) begin
      bad++; $display("FAIL %s up_passenger got=%b exp=%b", name, bus.up_passenger, up);
    end
    if (bus.down_passenger !== dn) begin
      bad++; $display("FAIL %s down_passenger got=%b exp=%b", name, bus.down_passenger, dn);
    end
    if (bus.up_total !== ut) begin
      bad++; $display("FAIL %s up_total got=%0d exp=%0d", name, bus.up_total, ut);
    end
    if (bus.down_total !== dt) begin
      bad++; $display("FAIL %s down_total got=%0d exp=%0d", name, bus.down_total, dt);
    end
  endtask

  initial begin
    vecs[0] = '{"zero", mk(0, 0, 0, 0, 0, 0, 0), 7'b0000000, 7'b0000000, 5'd0, 5'd0};
    vecs[1] = '{"mixed", mk(6'b000011, 6'b110001, 6'b000101, 6'b000010,
                             6'b000100, 6'b111000, 6'b000000),
                7'b0100111, 7'b0111110, 5'd6, 5'd6};
    vecs[2] = '{"extremes", mk(6'b111111, 0, 0, 0, 0, 0, 6'b111111),
                7'b0000001, 7'b1000000, 5'd6, 5'd6};
    vecs[3] = '{"saturate", mk(6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f, 6'h3f),
                7'b0111111, 7'b1111110, 5'd21, 5'd21};
    // floor 4: bit 3 is floor 5 (lowest up), bit 2 is floor 3 (highest down)
    vecs[4] = '{"f4_up", mk(0, 0, 0, 6'b001000, 0, 0, 0),
                7'b0001000, 7'b0000000, 5'd1, 5'd0};
    vecs[5] = '{"f4_down", mk(0, 0, 0, 6'b000100, 0, 0, 0),
                7'b0000000, 7'b0001000, 5'd0, 5'd1};
    vecs[6] = '{"f2_both", mk(0, 6'b110001, 0, 0, 0, 0, 0),
                7'b0000010, 7'b0000010, 5'd2, 5'd1};
    vecs[7] = '{"f6_split", mk(0, 0, 0, 0, 0, 6'b100001, 0),
                7'b0100000, 7'b0100000, 5'd1, 5'd1};

    // async reset with random inputs, before any clock edge
    drive(masks_t'({$urandom, $urandom}));
    #1 rst_n = 1'b0;
    #1 check("reset_async", '0, '0, '0, '0);
    @(posedge clk);
    #1 check("reset_held", '0, '0, '0, '0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk) drive(vecs[i].m);
      @(posedge clk);
      #1 check(vecs[i].name, vecs[i].up, vecs[i].dn, vecs[i].ut, vecs[i].dt);
    end

    // latency: new inputs must not appear before the next edge
    @(negedge clk) drive(vecs[3].m);
    #1 check("latency_hold", vecs[7].up, vecs[7].dn, vecs[7].ut, vecs[7].dt);
    @(posedge clk);
    #1 check("latency_load", vecs[3].up, vecs[3].dn, vecs[3].ut, vecs[3].dt);

    // mid-run reset between edges, then reload on first edge after release
    @(negedge clk) drive(vecs[1].m);
    @(posedge clk);
    #1 check("midrun_pre", vecs[1].up, vecs[1].dn, vecs[1].ut, vecs[1].dt);
    #1 rst_n = 1'b0;
    #1 check("midrun_rst", '0, '0, '0, '0);
    #1 rst_n = 1'b1;
    #1 check("midrun_rel", '0, '0, '0, '0);
    @(posedge clk);
    #1 check("midrun_reload", vecs[1].up, vecs[1].dn, vecs[1].ut, vecs[1].dt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
